vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter: CLK_DIV, 4, number of clk cycles per pixel (valid range 1..16).
REQ-002 Parameter: H_ACTIVE, 640, visible pixels per line.
REQ-003 Parameter: H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels.
REQ-004 Parameter: V_ACTIVE, 480, visible lines per frame.
REQ-005 Parameter: V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch in lines.
REQ-006 Port: clk  input  1  system clock; all logic on the rising edge.
REQ-007 Port: rst  input  1  reset, synchronous, active-high.
REQ-008 Port: pix_tick  output  1  one-clk pulse marking the cycle in which a new pixel position is presented.
REQ-009 Port: pixel_x  output  10  current horizontal counter, 0..H_TOTAL-1.
REQ-010 Port: pixel_y  output  10  current vertical counter, 0..V_TOTAL-1.
REQ-011 Port: video_on  output  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE.
REQ-012 Port: hsync  output  1  horizontal sync, active-low.
REQ-013 Port: vsync  output  1  vertical sync, active-low.
REQ-014 Port: frame_start  output  1  one-clk pulse coincident with pix_tick when position becomes (0,0).
REQ-015 Port: vgared / vgagreen / vgablue  output  4 each  test-pattern colour (see Configuration).

Function
REQ-016 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-017 Divider counts 0..CLK_DIV-1; on the edge where it reaches CLK_DIV-1 it wraps to 0, pix_tick is registered high for the next cycle, and counters advance on that same edge.
REQ-018 CLK_DIV=1: pix_tick constantly high after the first cycle out of reset; counters advance every clk.
REQ-019 Counter advance: pixel_x increments; at H_TOTAL-1 it wraps to 0 and pixel_y increments; pixel_y wraps from V_TOTAL-1 to 0 when pixel_x wraps.
REQ-020 hsync, vsync, video_on, frame_start and colour outputs are registered, updated on the same edge as the counters, and always consistent with the pixel_x/pixel_y values presented alongside them (zero relative latency).
REQ-021 hsync low iff H_ACTIVE+H_FP <= pixel_x < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-022 vsync low iff V_ACTIVE+V_FP <= pixel_y < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-023 frame_start high for exactly one clk per frame, on the tick presenting (0,0); low otherwise.
REQ-024 Outputs hold their values between ticks; no output changes on a non-tick edge except pix_tick and frame_start returning low.

Reset
REQ-025 While rst high at a clk edge: divider=0, pixel_x=H_TOTAL-1, pixel_y=V_TOTAL-1, hsync=1, vsync=1, video_on=0, pix_tick=0, frame_start=0, colour outputs=0.
REQ-026 First pix_tick after rst deasserts arrives CLK_DIV edges later, presenting (0,0) with frame_start=1 and video_on=1.
REQ-027 rst asserted mid-frame takes effect on the next edge, overriding any tick on that edge; no partial-frame state survives.

Configuration
REQ-028 Macro VGA_TIMING_TESTPAT_EN defined: colour outputs show 8 vertical bars, bar = pixel_x/80 (0..7), vgared={4{bar[2]}}, vgagreen={4{bar[1]}}, vgablue={4{bar[0]}}, all forced to 0 when video_on=0.
REQ-029 Macro VGA_TIMING_TESTPAT_EN undefined: colour outputs are constant 0 and no bar-decode logic is synthesised; all other behaviour is identical.

Verification
REQ-030 Release rst, CLK_DIV=4 -> pix_tick first high on 4th edge, pixel_x=0, pixel_y=0, frame_start=1, video_on=1, hsync=1, vsync=1.
REQ-031 Run one line -> hsync low for exactly 96 ticks (pixel_x 656..751); line period 800 ticks = 3200 clk.
REQ-032 Run two frames -> vsync low on lines 490..491 only; frame_start once per 420000 ticks; video_on high for exactly 307200 ticks per frame.
REQ-033 Assert rst at pixel (300,200) for 1 clk -> next edge shows pixel_x=799, pixel_y=524, all other outputs at reset values; restart per REQ-026.
REQ-034 VGA_TIMING_TESTPAT_EN defined: pixel_x=85,y=10 -> rgb=0,0,F; pixel_x=600 -> F,F,F; pixel_x=700 -> 0,0,0. Undefined: rgb=0 at all positions.
REQ-035 CLK_DIV=1 -> pix_tick high every cycle after first edge; line period 800 clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose: pixel-clock divider plus horizontal/vertical raster counters for a
// VGA-style display. All outputs are registered and change together on the
// clk edge that advances the raster position, so every sync/blank/colour
// value always belongs to the pixel_x/pixel_y presented alongside it.
//
// Optional feature: define VGA_TIMING_TESTPAT_EN to drive an 8-bar colour
// test pattern on vgared/vgagreen/vgablue. Without the macro the colour
// outputs are tied to zero and no pattern logic exists.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-high reset
//   pix_tick     out  one-clk pulse: a new pixel position is presented
//   pixel_x      out  horizontal counter, 0..H_TOTAL-1
//   pixel_y      out  vertical counter, 0..V_TOTAL-1
//   video_on     out  high inside the visible area
//   hsync        out  horizontal sync, active-low
//   vsync        out  vertical sync, active-low
//   frame_start  out  one-clk pulse with the tick presenting (0,0)
//   vgared/vgagreen/vgablue  out  4-bit test-pattern colour
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [3:0] vgared,
  output logic [3:0] vgagreen,
  output logic [3:0] vgablue
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Divider range 1..16 always fits in four bits.
  localparam logic [3:0] DIV_MAX  = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0] div_q, div_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       tick_q, tick_d;
  logic       fs_q, fs_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;

`ifdef VGA_TIMING_TESTPAT_EN
  logic [2:0] bar_d;
  logic [3:0] red_q, red_d;
  logic [3:0] green_q, green_d;
  logic [3:0] blue_q, blue_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; otherwise a latch would be inferred.
    div_d      = div_q;
    x_d        = x_q;
    y_d        = y_q;
    tick_d     = 1'b0;
    fs_d       = 1'b0;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    video_on_d = video_on_q;
`ifdef VGA_TIMING_TESTPAT_EN
    bar_d      = '0;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
`endif

    if (div_q == DIV_MAX) begin
      div_d  = '0;
      tick_d = 1'b1;
      if (x_q == H_MAX) begin
        x_d = '0;
        y_d = (y_q == V_MAX) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
      // Decode from the next position so the registered flags line up with
      // the counters they are presented with.
      hsync_d    = !((x_d >= HS_START) && (x_d < HS_END));
      vsync_d    = !((y_d >= VS_START) && (y_d < VS_END));
      video_on_d = (x_d < H_ACT) && (y_d < V_ACT);
      fs_d       = (x_d == '0) && (y_d == '0);
`ifdef VGA_TIMING_TESTPAT_EN
      // Eight 80-pixel-wide bars; blanked outside the visible area.
      bar_d   = 3'(x_d / 10'd80);
      red_d   = video_on_d ? {4{bar_d[2]}} : 4'h0;
      green_d = video_on_d ? {4{bar_d[1]}} : 4'h0;
      blue_d  = video_on_d ? {4{bar_d[0]}} : 4'h0;
`endif
    end else begin
      div_d = div_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the update order does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: reset parks the counters on the last position so the first
      // tick after release wraps cleanly to (0,0) and starts a frame.
      div_q      <= '0;
      x_q        <= H_MAX;
      y_q        <= V_MAX;
      tick_q     <= 1'b0;
      fs_q       <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
`ifdef VGA_TIMING_TESTPAT_EN
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
`endif
    end else begin
      div_q      <= div_d;
      x_q        <= x_d;
      y_q        <= y_d;
      tick_q     <= tick_d;
      fs_q       <= fs_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
`ifdef VGA_TIMING_TESTPAT_EN
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
`endif
    end
  end

  assign pix_tick    = tick_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign video_on    = video_on_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;

`ifdef VGA_TIMING_TESTPAT_EN
  assign vgared   = red_q;
  assign vgagreen = green_q;
  assign vgablue  = blue_q;
`else
  assign vgared   = 4'h0;
  assign vgagreen = 4'h0;
  assign vgablue  = 4'h0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Bench for vga_timing_gen. The main instance keeps the standard 800-pixel
// line and CLK_DIV=4 but uses a 7-line frame so two whole frames stay short.
// A second instance with CLK_DIV=1 shares clk/rst.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int CLK_DIV   = 4;
  localparam int V_ACT_T   = 3;
  localparam int V_FP_T    = 1;
  localparam int V_SYNC_T  = 2;
  localparam int V_BP_T    = 1;
  localparam int H_TOT     = 800;
  localparam int V_TOT     = V_ACT_T + V_FP_T + V_SYNC_T + V_BP_T;  // 7
  localparam int FRAME_CLK = H_TOT * V_TOT * CLK_DIV;               // 22400
  localparam int VS_LO     = V_ACT_T + V_FP_T;                      // 4
  localparam int VS_HI     = VS_LO + V_SYNC_T;                      // 6

`ifdef VGA_TIMING_TESTPAT_EN
  localparam bit TESTPAT = 1'b1;
`else
  localparam bit TESTPAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       pix_tick, video_on, hsync, vsync, frame_start;
  logic [9:0] pixel_x, pixel_y;
  logic [3:0] vgared, vgagreen, vgablue;

  logic       pix_tick1, video_on1, hsync1, vsync1, frame_start1;
  logic [9:0] pixel_x1, pixel_y1;
  logic [3:0] vgared1, vgagreen1, vgablue1;

  vga_timing_gen #(
    .CLK_DIV(CLK_DIV), .V_ACTIVE(V_ACT_T), .V_FP(V_FP_T),
    .V_SYNC(V_SYNC_T), .V_BP(V_BP_T)
  ) u_dut (
    .clk(clk), .rst(rst), .pix_tick(pix_tick), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .video_on(video_on), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .vgared(vgared), .vgagreen(vgagreen),
    .vgablue(vgablue)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .V_ACTIVE(V_ACT_T), .V_FP(V_FP_T),
    .V_SYNC(V_SYNC_T), .V_BP(V_BP_T)
  ) u_dut1 (
    .clk(clk), .rst(rst), .pix_tick(pix_tick1), .pixel_x(pixel_x1),
    .pixel_y(pixel_y1), .video_on(video_on1), .hsync(hsync1), .vsync(vsync1),
    .frame_start(frame_start1), .vgared(vgared1), .vgagreen(vgagreen1),
    .vgablue(vgablue1)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  bit done1   = 1'b0;

  task automatic check(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int x, input logic von);
    int         b;
    logic [2:0] bb;
    if (!von || !TESTPAT) return 12'h000;
    b  = x / 80;
    bb = b[2:0];
    return {{4{bb[2]}}, {4{bb[1]}}, {4{bb[0]}}};
  endfunction

  // {tick, x, y, hsync, vsync, video_on, frame_start, rgb}
  function automatic logic [36:0] pack(input logic t, input logic [9:0] x,
      input logic [9:0] y, input logic hs, input logic vs, input logic von,
      input logic fs, input logic [11:0] rgb);
    return {t, x, y, hs, vs, von, fs, rgb};
  endfunction

  // ---------------------------------------------------------------- scoreboard
  typedef struct {
    string       name;
    int          cyc;
    logic [36:0] exp;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      logic [36:0] act;
      mon_e = sb_q.pop_front();
      act = pack(pix_tick, pixel_x, pixel_y, hsync, vsync, video_on,
                 frame_start, {vgared, vgagreen, vgablue});
      check(mon_e.name, (mon_e.cyc == cyc) && (act === mon_e.exp),
            64'(act), 64'(mon_e.exp));
    end
  end

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic  rst_v;
    int    edges;
    logic  tick;
    int    x;
    int    y;
    logic  hs;
    logic  vs;
    logic  von;
    logic  fs;
    string name;
  } vec_t;

  vec_t vecs[18];

  task automatic wait_cyc(input int tgt);
    while (cyc < tgt) @(negedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    rst   = v.rst_v;
    e.name = v.name;
    e.cyc  = cyc + v.edges;
    e.exp  = pack(v.tick, 10'(v.x), 10'(v.y), v.hs, v.vs, v.von, v.fs,
                  exp_rgb(v.x, v.von));
    sb_q.push_back(e);
    wait_cyc(e.cyc);
  endtask

  // ---------------------------------------------------------------- main
  initial begin : main
    int          mx, my, bad, first_bad, ticks, hs_low, vs_low, von_cnt;
    int          fs_seen, fs_first, fs_second, k;
    logic [36:0] ex, ac, bad_act, bad_exp;
    bit          t, hs_e, vs_e, von_e, fs_e;

    rst = 1'b1;
    //          rst   edges        tick  x    y          hs    vs    von   fs
    vecs[0]  = '{1'b1, 1,          1'b0, 799, V_TOT-1,   1'b1, 1'b1, 1'b0, 1'b0, "reset_state"};
    vecs[1]  = '{1'b0, 1,          1'b0, 799, V_TOT-1,   1'b1, 1'b1, 1'b0, 1'b0, "hold_after_release"};
    vecs[2]  = '{1'b0, 2,          1'b0, 799, V_TOT-1,   1'b1, 1'b1, 1'b0, 1'b0, "no_tick_before_div"};
    vecs[3]  = '{1'b0, 1,          1'b1, 0,   0,         1'b1, 1'b1, 1'b1, 1'b1, "first_tick_origin"};
    vecs[4]  = '{1'b0, 1,          1'b0, 0,   0,         1'b1, 1'b1, 1'b1, 1'b0, "tick_pulse_ends"};
    vecs[5]  = '{1'b0, 3,          1'b1, 1,   0,         1'b1, 1'b1, 1'b1, 1'b0, "second_tick"};
    vecs[6]  = '{1'b0, 4*638,      1'b1, 639, 0,         1'b1, 1'b1, 1'b1, 1'b0, "last_active_px"};
    vecs[7]  = '{1'b0, 4,          1'b1, 640, 0,         1'b1, 1'b1, 1'b0, 1'b0, "first_blank_px"};
    vecs[8]  = '{1'b0, 4*16,       1'b1, 656, 0,         1'b0, 1'b1, 1'b0, 1'b0, "hsync_start"};
    vecs[9]  = '{1'b0, 4*95,       1'b1, 751, 0,         1'b0, 1'b1, 1'b0, 1'b0, "hsync_last"};
    vecs[10] = '{1'b0, 4,          1'b1, 752, 0,         1'b1, 1'b1, 1'b0, 1'b0, "hsync_release"};
    vecs[11] = '{1'b0, 4*47,       1'b1, 799, 0,         1'b1, 1'b1, 1'b0, 1'b0, "line_end"};
    vecs[12] = '{1'b0, 4,          1'b1, 0,   1,         1'b1, 1'b1, 1'b1, 1'b0, "line_wrap_3200clk"};
    vecs[13] = '{1'b0, 1+4*1100,   1'b1, 300, 2,         1'b1, 1'b1, 1'b1, 1'b0, "pos_300_2"};
    vecs[14] = '{1'b0, 3,          1'b0, 300, 2,         1'b1, 1'b1, 1'b1, 1'b0, "hold_before_rst"};
    vecs[15] = '{1'b1, 1,          1'b0, 799, V_TOT-1,   1'b1, 1'b1, 1'b0, 1'b0, "rst_overrides_tick"};
    vecs[16] = '{1'b0, 3,          1'b0, 799, V_TOT-1,   1'b1, 1'b1, 1'b0, 1'b0, "hold_after_rst"};
    vecs[17] = '{1'b0, 1,          1'b1, 0,   0,         1'b1, 1'b1, 1'b1, 1'b1, "restart_origin"};

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Two whole frames from the tick presenting (0,1), checked cycle by
    // cycle against an independent raster model, plus aggregate counts.
    mx = 0; my = 1; bad = 0; first_bad = 0; ticks = 0; hs_low = 0;
    vs_low = 0; von_cnt = 0; fs_seen = 0; fs_first = 0; fs_second = 0;
    bad_act = '0; bad_exp = '0;
    for (int i = 0; i < 2*FRAME_CLK; i++) begin
      if (i > 0) @(negedge clk);
      t = (i % CLK_DIV) == 0;
      if (t && i > 0) begin
        if (mx == H_TOT-1) begin
          mx = 0;
          my = (my == V_TOT-1) ? 0 : my + 1;
        end else begin
          mx = mx + 1;
        end
      end
      hs_e  = !(mx >= 656 && mx < 752);
      vs_e  = !(my >= VS_LO && my < VS_HI);
      von_e = (mx < 640) && (my < V_ACT_T);
      fs_e  = t && mx == 0 && my == 0;
      ex = pack(t, 10'(mx), 10'(my), hs_e, vs_e, von_e, fs_e, exp_rgb(mx, von_e));
      ac = pack(pix_tick, pixel_x, pixel_y, hsync, vsync, video_on,
                frame_start, {vgared, vgagreen, vgablue});
      if (ac !== ex) begin
        bad++;
        if (bad == 1) begin
          first_bad = i; bad_act = ac; bad_exp = ex;
        end
      end
      if (pix_tick === 1'b1) begin
        ticks++;
        if (hsync === 1'b0) hs_low++;
        if (vsync === 1'b0) vs_low++;
        if (video_on === 1'b1) von_cnt++;
      end
      if (frame_start === 1'b1) begin
        fs_seen++;
        if (fs_seen == 1) fs_first = i;
        else if (fs_seen == 2) fs_second = i;
      end
    end
    check($sformatf("frame_model(first bad cycle %0d of %0d bad)", first_bad, bad),
          bad == 0, 64'(bad_act), 64'(bad_exp));
    check("tick_count", ticks == 2*H_TOT*V_TOT, ticks, 2*H_TOT*V_TOT);
    check("hsync_low_ticks", hs_low == 2*V_TOT*96, hs_low, 2*V_TOT*96);
    check("vsync_low_ticks", vs_low == 2*V_SYNC_T*H_TOT, vs_low, 2*V_SYNC_T*H_TOT);
    check("video_on_ticks", von_cnt == 2*640*V_ACT_T, von_cnt, 2*640*V_ACT_T);
    check("frame_start_count", fs_seen == 2, fs_seen, 2);
    check("frame_start_period", fs_second - fs_first == FRAME_CLK,
          fs_second - fs_first, FRAME_CLK);

    for (int i = 13; i < 18; i++) run_vec(vecs[i]);

    check("scoreboard_drained", sb_q.size() == 0, sb_q.size(), 0);

    k = 0;
    while (!done1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check("div1_finished", done1, done1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------------------------------------------------------- CLK_DIV=1
  initial begin : div1_chk
    int          bad1, k, x, y;
    logic [36:0] ex, ac, ba, be;
    bit          hs_e, von_e;
    bad1 = 0; k = 0; ba = '0; be = '0;
    @(negedge clk);
    while (rst !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("div1_release_seen", rst === 1'b0, 64'(rst), 0);
    // The negedge where release is first seen follows the first edge that
    // sampled rst low, so the first tick is already visible here.
    for (int i = 0; i <= 1600; i++) begin
      if (i > 0) @(negedge clk);
      x = i % H_TOT;
      y = i / H_TOT;
      hs_e  = !(x >= 656 && x < 752);
      von_e = (x < 640) && (y < V_ACT_T);
      ex = pack(1'b1, 10'(x), 10'(y), hs_e, 1'b1, von_e, (x == 0 && y == 0),
                exp_rgb(x, von_e));
      ac = pack(pix_tick1, pixel_x1, pixel_y1, hsync1, vsync1, video_on1,
                frame_start1, {vgared1, vgagreen1, vgablue1});
      if (ac !== ex) begin
        bad1++;
        if (bad1 == 1) begin ba = ac; be = ex; end
      end
      if (i == 0) check("div1_first_edge_origin", ac === ex, 64'(ac), 64'(ex));
      if (i == H_TOT)
        check("div1_line_period_800clk", {pixel_x1, pixel_y1} === {10'd0, 10'd1},
              64'({pixel_x1, pixel_y1}), 64'({10'd0, 10'd1}));
    end
    check("div1_every_clk", bad1 == 0, 64'(ba), 64'(be));
    done1 = 1'b1;
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
